jump_unit: RTL and testbench

JUMP_UNIT -- requirements
Module: jump_unit

---
 rtl/jump_unit.sv | 141 ++++++++++++++
 tb/tb_jump_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_unit.sv
// Jump unit: decodes JMP/JZ/JNZ/CALL/RET at step strobes and drives a registered jump to the PC.
// Ports: clk, Clear, step, op, target, zero, Caddr in; Jaddr, Jflag, depth, empty, full, fault out.
module jump_unit #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       Clear,
  input  logic       step,
  input  logic [2:0] op,
  input  logic [9:0] target,
  input  logic       zero,
  input  logic [9:0] Caddr,
  output logic [9:0] Jaddr,
  output logic       Jflag,
  output logic [4:0] depth,
  output logic       empty,
  output logic       full,
  output logic       fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PMAX = PW'(DEPTH);

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_JNZ  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FAULT
  } state_t;

  state_t        r_state;
  logic [9:0]    r_jaddr;
  logic          r_jflag;
  logic [PW-1:0] r_ptr;
  logic          r_empty;
  logic          r_full;
  logic          r_fault;
  logic [9:0]    r_stack [DEPTH];

  logic          w_go;
  logic          w_jmp;
  logic          w_jz;
  logic          w_jnz;
  logic          w_call;
  logic          w_ret;
  logic          w_push;
  logic [PW-1:0] w_ptr_inc;
  logic [PW-1:0] w_ptr_dec;
  logic [9:0]    w_top;
  logic [9:0]    w_ret_addr;

  // Steps are only accepted in IDLE; ISSUE and FAULT drop them.
  assign w_go   = step && (r_state == S_IDLE);
  assign w_jmp  = (op == OP_JMP);
  assign w_jz   = (op == OP_JZ);
  assign w_jnz  = (op == OP_JNZ);
  assign w_call = (op == OP_CALL);
  assign w_ret  = (op == OP_RET);

  assign w_push     = w_go && w_call && !r_full && !Clear;
  assign w_ptr_inc  = r_ptr + 1'b1;
  assign w_ptr_dec  = r_ptr - 1'b1;
  assign w_top      = r_stack[w_ptr_dec[AW-1:0]];
  assign w_ret_addr = Caddr + 10'd1;

  // Entry storage carries no reset: an entry is only read after a push wrote it.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_ptr[AW-1:0]] <= w_ret_addr;
  end

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      r_state <= S_IDLE;
      r_jaddr <= '0;
      r_jflag <= 1'b0;
      r_ptr   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_jflag <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (step) begin
            unique case (1'b1)
              w_jmp, (w_jz && zero), (w_jnz && !zero): begin
                r_jaddr <= target;
                r_jflag <= 1'b1;
                r_state <= S_ISSUE;
              end
              w_call: begin
                if (r_full) begin
                  r_fault <= 1'b1;
                  r_state <= S_FAULT;
                end else begin
                  r_jaddr <= target;
                  r_jflag <= 1'b1;
                  r_ptr   <= w_ptr_inc;
                  r_empty <= 1'b0;
                  r_full  <= (w_ptr_inc == PMAX);
                  r_state <= S_ISSUE;
                end
              end
              w_ret: begin
                if (r_empty) begin
                  r_fault <= 1'b1;
                  r_state <= S_FAULT;
                end else begin
                  r_jaddr <= w_top;
                  r_jflag <= 1'b1;
                  r_ptr   <= w_ptr_dec;
                  r_full  <= 1'b0;
                  r_empty <= (w_ptr_dec == '0);
                  r_state <= S_ISSUE;
                end
              end
              default: ;
            endcase
          end
        end
        S_ISSUE: r_state <= S_IDLE;
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Jaddr = r_jaddr;
  assign Jflag = r_jflag;
  assign depth = 5'(r_ptr);
  assign empty = r_empty;
  assign full  = r_full;
  assign fault = r_fault;

endmodule

// File: tb/tb_jump_unit.sv
// Directed bench for jump_unit: branch decode, call/return stack, faults and Clear.
// Drives on negedge, checks on negedge (or #1 after an async Clear).
module tb_jump_unit;

  logic       clk;
  logic       Clear;
  logic       step;
  logic [2:0] op;
  logic [9:0] target;
  logic       zero;
  logic [9:0] Caddr;
  logic [9:0] Jaddr;
  logic       Jflag;
  logic [4:0] depth;
  logic       empty;
  logic       full;
  logic       fault;

  int n_chk;
  int n_err;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] JMP  = 3'b001;
  localparam logic [2:0] JZ   = 3'b010;
  localparam logic [2:0] JNZ  = 3'b011;
  localparam logic [2:0] CALL = 3'b100;
  localparam logic [2:0] RET  = 3'b101;

  jump_unit #(.DEPTH(8)) dut (
    .clk    (clk),
    .Clear  (Clear),
    .step   (step),
    .op     (op),
    .target (target),
    .zero   (zero),
    .Caddr  (Caddr),
    .Jaddr  (Jaddr),
    .Jflag  (Jflag),
    .depth  (depth),
    .empty  (empty),
    .full   (full),
    .fault  (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; one-cycle step, returns at the next negedge.
  task automatic do_step(input logic [2:0] o, input logic [9:0] t,
                         input logic z, input logic [9:0] ca);
    step   = 1'b1;
    op     = o;
    target = t;
    zero   = z;
    Caddr  = ca;
    @(negedge clk);
    step   = 1'b0;
    op     = NOP;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".Jflag"}, int'(Jflag), 0);
    chk({tag, ".Jaddr"}, int'(Jaddr), 0);
    chk({tag, ".depth"}, int'(depth), 0);
    chk({tag, ".empty"}, int'(empty), 1);
    chk({tag, ".full"},  int'(full),  0);
    chk({tag, ".fault"}, int'(fault), 0);
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    @(negedge clk);
    Clear = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    Clear  = 1'b1;
    step   = 1'b0;
    op     = NOP;
    target = '0;
    zero   = 1'b0;
    Caddr  = '0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    Clear = 1'b0;
    idle();

    // JMP
    do_step(JMP, 10'h155, 1'b0, 10'h000);
    chk("jmp.flag", int'(Jflag), 1);
    chk("jmp.addr", int'(Jaddr), 'h155);
    idle();
    chk("jmp.flag2", int'(Jflag), 0);
    chk("jmp.addr2", int'(Jaddr), 'h155);

    // JZ / JNZ
    do_step(JZ, 10'h0AA, 1'b0, 10'h000);
    chk("jz0.flag", int'(Jflag), 0);
    chk("jz0.addr", int'(Jaddr), 'h155);
    do_step(JZ, 10'h010, 1'b1, 10'h000);
    chk("jz1.flag", int'(Jflag), 1);
    chk("jz1.addr", int'(Jaddr), 'h010);
    idle();
    do_step(JNZ, 10'h0BB, 1'b1, 10'h000);
    chk("jnz1.flag", int'(Jflag), 0);
    chk("jnz1.addr", int'(Jaddr), 'h010);
    do_step(JNZ, 10'h011, 1'b0, 10'h000);
    chk("jnz0.flag", int'(Jflag), 1);
    chk("jnz0.addr", int'(Jaddr), 'h011);
    idle();
    do_step(3'b110, 10'h1FF, 1'b0, 10'h000);
    chk("op6.flag", int'(Jflag), 0);
    chk("op6.addr", int'(Jaddr), 'h011);

    // CALL with Caddr wrap, then RET
    do_step(CALL, 10'h020, 1'b0, 10'h3FF);
    chk("call.flag",  int'(Jflag), 1);
    chk("call.addr",  int'(Jaddr), 'h020);
    chk("call.depth", int'(depth), 1);
    chk("call.empty", int'(empty), 0);
    idle();
    do_step(RET, 10'h000, 1'b0, 10'h021);
    chk("ret.flag",  int'(Jflag), 1);
    chk("ret.addr",  int'(Jaddr), 'h000);
    chk("ret.depth", int'(depth), 0);
    chk("ret.empty", int'(empty), 1);
    idle();

    // Step while in ISSUE is dropped
    do_step(CALL, 10'h040, 1'b0, 10'h005);
    chk("iss.flag", int'(Jflag), 1);
    do_step(JMP, 10'h300, 1'b0, 10'h000);
    chk("iss.flag2", int'(Jflag), 0);
    chk("iss.addr",  int'(Jaddr), 'h040);
    chk("iss.depth", int'(depth), 1);
    idle();
    chk("iss.flag3", int'(Jflag), 0);
    do_step(RET, 10'h000, 1'b0, 10'h041);
    chk("iss.ret",   int'(Jaddr), 'h006);
    chk("iss.empty", int'(empty), 1);
    idle();

    // Fill the stack
    for (int i = 0; i < 8; i++) begin
      do_step(CALL, 10'(10'h100 + i), 1'b0, 10'(i));
      chk("fill.flag",  int'(Jflag), 1);
      chk("fill.depth", int'(depth), i + 1);
      chk("fill.full",  int'(full),  (i == 7) ? 1 : 0);
      idle();
    end
    // LIFO: top is Caddr 7 + 1
    do_step(RET, 10'h000, 1'b0, 10'h000);
    chk("lifo.addr",  int'(Jaddr), 8);
    chk("lifo.depth", int'(depth), 7);
    chk("lifo.full",  int'(full),  0);
    idle();
    do_step(RET, 10'h000, 1'b0, 10'h000);
    chk("lifo.addr2", int'(Jaddr), 7);
    idle();
    do_step(CALL, 10'h106, 1'b0, 10'h006);
    idle();
    do_step(CALL, 10'h107, 1'b0, 10'h007);
    chk("refill.full", int'(full), 1);
    idle();

    // Overflow
    do_step(CALL, 10'h200, 1'b0, 10'h008);
    chk("ovf.flag",  int'(Jflag), 0);
    chk("ovf.fault", int'(fault), 1);
    chk("ovf.addr",  int'(Jaddr), 'h107);
    chk("ovf.depth", int'(depth), 8);
    do_step(RET, 10'h000, 1'b0, 10'h000);
    idle();
    chk("flt.flag",  int'(Jflag), 0);
    chk("flt.depth", int'(depth), 8);
    chk("flt.fault", int'(fault), 1);
    do_step(JMP, 10'h333, 1'b0, 10'h000);
    chk("flt.jmp",   int'(Jflag), 0);
    chk("flt.addr",  int'(Jaddr), 'h107);
    do_clear();
    chk_reset("clr1");

    // Ready on first clk after Clear
    do_step(JMP, 10'h0F0, 1'b0, 10'h000);
    chk("post.flag", int'(Jflag), 1);
    chk("post.addr", int'(Jaddr), 'h0F0);
    idle();

    // Underflow
    do_step(RET, 10'h000, 1'b0, 10'h000);
    chk("unf.flag",  int'(Jflag), 0);
    chk("unf.fault", int'(fault), 1);
    chk("unf.depth", int'(depth), 0);
    do_clear();
    chk_reset("clr2");

    // Clear during ISSUE kills the pulse immediately
    do_step(JMP, 10'h222, 1'b0, 10'h000);
    chk("ci.flag", int'(Jflag), 1);
    Clear = 1'b1;
    #1;
    chk("ci.flag0", int'(Jflag), 0);
    chk("ci.addr0", int'(Jaddr), 0);
    @(negedge clk);
    Clear = 1'b0;
    idle();

    // Clear together with a CALL step
    do_step(CALL, 10'h0C0, 1'b0, 10'h010);
    idle();
    chk("pre.depth", int'(depth), 1);
    Clear = 1'b1;
    step  = 1'b1;
    op    = CALL;
    target = 10'h0D0;
    Caddr  = 10'h020;
    @(negedge clk);
    chk_reset("cc");
    step  = 1'b0;
    op    = NOP;
    Clear = 1'b0;
    idle();
    chk("cc.flag", int'(Jflag), 0);
    chk("cc.depth", int'(depth), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
